// File: rtl/mem_req_initiator.sv
// Bus initiator that turns a valid/ready command stream into req/gnt/rvalid memory requests.
// It tracks in-order responses and returns them through a credit-limited response FIFO.
module mem_req_initiator #(
  parameter int RspDepth  = 4,
  parameter int AddrWidth = 32
) (
  input  logic                 clk_sys,
  input  logic                 rst_sys,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [3:0]           cmd_be,
  input  logic [AddrWidth-1:0] cmd_addr,
  input  logic [31:0]          cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_we,
  output logic                 rsp_err,
  output logic                 mem_req,
  input  logic                 mem_gnt,
  output logic                 mem_we,
  output logic [3:0]           mem_be,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_rvalid,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_err,
  output logic                 busy,
  output logic                 proto_err
);

  localparam int PtrW = $clog2(RspDepth);
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(RspDepth);

  logic [CntW-1:0] out_cnt;
  logic [CntW-1:0] rsp_count;
  logic [CntW-1:0] occ;
  logic [PtrW-1:0] tag_wr;
  logic [PtrW-1:0] tag_rd;
  logic [PtrW-1:0] rsp_wr;
  logic [PtrW-1:0] rsp_rd;

  logic            tag_mem       [RspDepth];
  logic [31:0]     rsp_rdata_mem [RspDepth];
  logic            rsp_we_mem    [RspDepth];
  logic            rsp_err_mem   [RspDepth];

  logic accept;
  logic grant;
  logic resp;
  logic rsp_pop;
  logic tag_we;

  // Every in-flight transfer owns one response slot, so the FIFO can never overflow.
  assign occ       = CntW'(mem_req) + out_cnt + rsp_count;
  assign cmd_ready = (!mem_req || mem_gnt) && (occ < DepthC);
  assign accept    = cmd_valid && cmd_ready;
  assign grant     = mem_req && mem_gnt;
  assign resp      = mem_rvalid && (out_cnt != '0);
  assign rsp_valid = (rsp_count != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign busy      = (occ != '0);
  assign tag_we    = tag_mem[tag_rd];

  assign rsp_rdata = rsp_rdata_mem[rsp_rd];
  assign rsp_we    = rsp_we_mem[rsp_rd];
  assign rsp_err   = rsp_err_mem[rsp_rd];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (accept) begin
      mem_req   <= 1'b1;
      mem_we    <= cmd_we;
      mem_be    <= cmd_be;
      mem_addr  <= cmd_addr;
      mem_wdata <= cmd_wdata;
    end else if (grant) begin
      mem_req   <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      out_cnt   <= '0;
      tag_wr    <= '0;
      tag_rd    <= '0;
      rsp_wr    <= '0;
      rsp_rd    <= '0;
      rsp_count <= '0;
      proto_err <= 1'b0;
    end else begin
      case ({grant, resp})
        2'b10:   out_cnt <= out_cnt + CntW'(1);
        2'b01:   out_cnt <= out_cnt - CntW'(1);
        default: out_cnt <= out_cnt;
      endcase
      if (grant) tag_wr <= tag_wr + PtrW'(1);
      if (resp) begin
        tag_rd <= tag_rd + PtrW'(1);
        rsp_wr <= rsp_wr + PtrW'(1);
      end
      if (rsp_pop) rsp_rd <= rsp_rd + PtrW'(1);
      case ({resp, rsp_pop})
        2'b10:   rsp_count <= rsp_count + CntW'(1);
        2'b01:   rsp_count <= rsp_count - CntW'(1);
        default: rsp_count <= rsp_count;
      endcase
      if (mem_rvalid && (out_cnt == '0)) proto_err <= 1'b1;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and counts alone define what is valid.
  always_ff @(posedge clk_sys) begin
    if (grant) tag_mem[tag_wr] <= mem_we;
    if (resp) begin
      rsp_rdata_mem[rsp_wr] <= tag_we ? 32'h0 : mem_rdata;
      rsp_we_mem[rsp_wr]    <= tag_we;
      rsp_err_mem[rsp_wr]   <= mem_err;
    end
  end

endmodule

// File: tb/tb_mem_req_initiator.sv
// Directed bench for mem_req_initiator with a small RAM responder.
// The responder returns rvalid one cycle after each grant.
module tb_mem_req_initiator;

  logic        clk_sys = 1'b0;
  logic        rst_sys;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [3:0]  cmd_be;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_we;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        busy;
  logic        proto_err;

  logic        gnt_en;
  logic        spur;
  logic        err_in;
  logic        rv_q;
  logic [31:0] rd_q;
  logic [31:0] ram [256];
  int          grants;
  int          req_cycles;
  int          checks;
  int          errors;

  always #5 clk_sys = ~clk_sys;

  mem_req_initiator #(.RspDepth(4), .AddrWidth(32)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_be(cmd_be),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_we(rsp_we), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .busy(busy), .proto_err(proto_err)
  );

  assign mem_gnt    = mem_req && gnt_en;
  assign mem_rvalid = rv_q || spur;
  assign mem_rdata  = rd_q;
  assign mem_err    = err_in;

  always @(posedge clk_sys) begin
    if (rst_sys) begin
      rv_q <= 1'b0;
      rd_q <= 32'h0;
    end else begin
      rv_q <= 1'b0;
      if (mem_req && mem_gnt) begin
        rv_q <= 1'b1;
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          rd_q <= 32'h0;
        end else begin
          rd_q <= ram[mem_addr[9:2]];
        end
      end
    end
  end

  always @(negedge clk_sys) begin
    if (mem_req) req_cycles++;
    if (mem_req && mem_gnt) grants++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic drive_cmd(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_be    = be;
    cmd_addr  = addr;
    cmd_wdata = wdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int k;
    int g0;
    int r0;
    logic acc;

    checks = 0; errors = 0; grants = 0; req_cycles = 0;
    rst_sys = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_be = 4'h0;
    cmd_addr = 32'h0; cmd_wdata = 32'h0; rsp_ready = 1'b0;
    gnt_en = 1'b1; spur = 1'b0; err_in = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[8'h40] = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++) ram[8'h80 + i] = 32'h1000 + i;
    tick(); tick();
    rst_sys = 1'b0;
    #1;

    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_cmd_ready", cmd_ready, 1);

    // Single read with zero-wait grant.
    r0 = req_cycles;
    drive_cmd(1'b0, 4'hF, 32'h100, 32'h0);
    tick();
    cmd_valid = 1'b0;
    check("rd_mem_req", mem_req, 1);
    check("rd_mem_addr", mem_addr, 32'h100);
    tick();
    check("rd_req_drop", mem_req, 0);
    check("rd_rsp_early", rsp_valid, 0);
    tick();
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    check("rd_rsp_we", rsp_we, 0);
    check("rd_req_cycles", req_cycles - r0, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rd_rsp_popped", rsp_valid, 0);
    check("rd_busy_idle", busy, 0);

    // Partial write followed by a read of the same word.
    drive_cmd(1'b1, 4'b0011, 32'h40, 32'h12345678);
    err_in = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_be", mem_be, 4'b0011);
    check("wr_mem_wdata", mem_wdata, 32'h12345678);
    tick();
    tick();
    err_in = 1'b0;
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_we", rsp_we, 1);
    check("wr_rsp_rdata", rsp_rdata, 0);
    check("wr_rsp_err", rsp_err, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    drive_cmd(1'b0, 4'hF, 32'h40, 32'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("wrrd_rsp_valid", rsp_valid, 1);
    check("wrrd_rsp_rdata", rsp_rdata, 32'h00005678);
    check("wrrd_rsp_we", rsp_we, 0);
    check("wrrd_rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Grant withheld for five cycles.
    gnt_en = 1'b0;
    drive_cmd(1'b1, 4'hF, 32'h80, 32'hA5A5A5A5);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_mem_req", mem_req, 1);
      check("stall_mem_addr", mem_addr, 32'h80);
      check("stall_mem_wdata", mem_wdata, 32'hA5A5A5A5);
      check("stall_cmd_ready", cmd_ready, 0);
      tick();
    end
    gnt_en = 1'b1;
    tick();
    check("stall_req_drop", mem_req, 0);
    tick();
    check("stall_rsp_valid", rsp_valid, 1);
    check("stall_rsp_we", rsp_we, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("stall_single_rsp", rsp_valid, 0);

    // Eight back-to-back reads against a blocked response stream.
    g0 = grants;
    idx = 0;
    drive_cmd(1'b0, 4'hF, 32'h200, 32'h0);
    for (int c = 0; c < 20; c++) begin
      acc = cmd_valid && cmd_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 8) cmd_addr = 32'h200 + 32'(4 * idx);
        else cmd_valid = 1'b0;
      end
    end
    #1;
    check("credit_accepted", idx, 4);
    check("credit_grants", grants - g0, 4);
    check("credit_cmd_ready", cmd_ready, 0);
    check("credit_busy", busy, 1);
    rsp_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 80 && k < 8; c++) begin
      acc = cmd_valid && cmd_ready;
      if (rsp_valid) begin
        check("order_rdata", rsp_rdata, 32'h1000 + k);
        k++;
      end
      tick();
      if (acc) begin
        idx++;
        if (idx < 8) cmd_addr = 32'h200 + 32'(4 * idx);
        else cmd_valid = 1'b0;
      end
    end
    rsp_ready = 1'b0;
    check("order_rsp_count", k, 8);
    check("order_grants", grants - g0, 8);
    tick();
    check("order_idle", busy, 0);

    // Spurious rvalid while idle.
    spur = 1'b1;
    tick();
    spur = 1'b0;
    check("spur_proto_err", proto_err, 1);
    check("spur_rsp_valid", rsp_valid, 0);
    tick(); tick();
    check("spur_sticky", proto_err, 1);
    rst_sys = 1'b1;
    tick();
    rst_sys = 1'b0;
    check("spur_cleared", proto_err, 0);

    // Reset with transfers in flight.
    drive_cmd(1'b0, 4'hF, 32'h200, 32'h0);
    tick();
    cmd_addr = 32'h204;
    tick();
    cmd_addr = 32'h208;
    tick();
    cmd_valid = 1'b0;
    check("mid_busy", busy, 1);
    rst_sys = 1'b1;
    tick();
    rst_sys = 1'b0;
    check("mid_mem_req", mem_req, 0);
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_busy_clr", busy, 0);
    check("mid_cmd_ready", cmd_ready, 1);
    tick();
    check("mid_no_proto_err", proto_err, 0);
    check("mid_no_rsp", rsp_valid, 0);

    // Operation resumes cleanly after the reset.
    drive_cmd(1'b0, 4'hF, 32'h100, 32'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("post_rsp_valid", rsp_valid, 1);
    check("post_rsp_rdata", rsp_rdata, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
